// File: rtl/arb_mux_pkg.sv
// Shared types for the round-robin arbitrating multiplexer.
package arb_mux_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_HOLD = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_arb_mux_oreg.sv
// One-entry valid/ready register slice; accepts a new beat whenever empty or being drained.
module rr_arb_mux_oreg #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             arst_ni,
    input  logic [WIDTH-1:0] in_data_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic [WIDTH-1:0] out_data_o,
    output logic             out_valid_o,
    input  logic             out_ready_i
);

    logic             full_q, full_d;
    logic [WIDTH-1:0] data_q, data_d;

    assign in_ready_o = !full_q | out_ready_i;

    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (in_ready_o) begin
            full_d = in_valid_i;
            if (in_valid_i) begin
                data_d = in_data_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign out_data_o  = data_q;
    assign out_valid_o = full_q;

endmodule

// File: rtl/rr_arb_mux.sv
// N-to-1 round-robin arbitrating mux with source-index tag.
// Define RR_ARB_MUX_OUT_REG_EN to register the output stream (1-cycle latency).
module rr_arb_mux
    import arb_mux_pkg::*;
#(
    parameter  int NUM_ELEM   = 6,
    parameter  int ELEM_WIDTH = 8,
    localparam int SEL_W      = $clog2(NUM_ELEM)
) (
    input  logic                                 clk_i,
    input  logic                                 arst_ni,
    input  logic [NUM_ELEM-1:0][ELEM_WIDTH-1:0]  i_i,
    input  logic [NUM_ELEM-1:0]                  i_valid_i,
    output logic [NUM_ELEM-1:0]                  i_ready_o,
    output logic [ELEM_WIDTH-1:0]                o_o,
    output logic [SEL_W-1:0]                     o_sel_o,
    output logic                                 o_valid_o,
    input  logic                                 o_ready_i
);

    arb_state_e       state_q, state_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [SEL_W-1:0] hold_q, hold_d;
    logic [SEL_W-1:0] search_g;
    logic [SEL_W-1:0] grant;
    logic             any_valid;
    logic             arb_valid;
    logic             int_ready;
    logic             xfer;
    logic [ELEM_WIDTH-1:0] arb_data;
    logic [SEL_W-1:0]      arb_sel;

    assign any_valid = |i_valid_i;

    // Walk from the highest offset down so the nearest valid index after ptr_q wins.
    always_comb begin
        int idx;
        search_g = '0;
        idx      = 0;
        for (int k = NUM_ELEM - 1; k >= 0; k--) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_ELEM) begin
                idx = idx - NUM_ELEM;
            end
            if (i_valid_i[idx]) begin
                search_g = SEL_W'(idx);
            end
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q <= ARB_IDLE;
            ptr_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        ptr_d   = ptr_q;
        case (state_q)
            ARB_IDLE: begin
                if (any_valid && !int_ready) begin
                    state_d = ARB_HOLD;
                    hold_d  = search_g;
                end
            end
            ARB_HOLD: begin
                if (int_ready) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
        if (xfer) begin
            ptr_d = (grant == SEL_W'(NUM_ELEM - 1)) ? '0 : grant + 1'b1;
        end
    end

    // Once a grant is offered and stalled it is frozen in hold_q until accepted.
    always_comb begin
        grant     = (state_q == ARB_HOLD) ? hold_q : search_g;
        arb_valid = arst_ni & ((state_q == ARB_HOLD) | any_valid);
        arb_data  = '0;
        arb_sel   = '0;
        i_ready_o = '0;
        if (arb_valid) begin
            arb_data         = i_i[grant];
            arb_sel          = grant;
            i_ready_o[grant] = int_ready;
        end
        xfer = arb_valid & int_ready;
    end

`ifdef RR_ARB_MUX_OUT_REG_EN
    logic [SEL_W+ELEM_WIDTH-1:0] slice_data;

    rr_arb_mux_oreg #(
        .WIDTH (SEL_W + ELEM_WIDTH)
    ) u_oreg (
        .clk_i       (clk_i),
        .arst_ni     (arst_ni),
        .in_data_i   ({arb_sel, arb_data}),
        .in_valid_i  (arb_valid),
        .in_ready_o  (int_ready),
        .out_data_o  (slice_data),
        .out_valid_o (o_valid_o),
        .out_ready_i (o_ready_i)
    );

    assign {o_sel_o, o_o} = slice_data;
`else
    assign int_ready = o_ready_i;
    assign o_valid_o = arb_valid;
    assign o_o       = arb_data;
    assign o_sel_o   = arb_sel;
`endif

endmodule

// File: tb/tb_rr_arb_mux.sv
// Scoreboard bench for rr_arb_mux: queue-driven sources, output monitor pops expected beats.
module tb_rr_arb_mux;

    localparam int N  = 6;
    localparam int W  = 8;
    localparam int SW = 3;

    logic                 clk = 1'b0;
    logic                 arst_ni;
    logic [N-1:0][W-1:0]  i_i;
    logic [N-1:0]         i_valid_i;
    logic [N-1:0]         i_ready_o;
    logic [W-1:0]         o_o;
    logic [SW-1:0]        o_sel_o;
    logic                 o_valid_o;
    logic                 o_ready_i;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [SW-1:0] sel;
        logic [W-1:0]  data;
    } exp_t;

    logic [W-1:0] src_q [N][$];
    logic [W-1:0] gen_q [N][$];
    exp_t         exp_q [$];
    bit           rand_mode = 1'b0;
    int           out_cnt = 0;
    int           wait_cnt [N];
    int           issued = 0;

    always #5 clk = ~clk;

    rr_arb_mux #(
        .NUM_ELEM   (N),
        .ELEM_WIDTH (W)
    ) dut (
        .clk_i     (clk),
        .arst_ni   (arst_ni),
        .i_i       (i_i),
        .i_valid_i (i_valid_i),
        .i_ready_o (i_ready_o),
        .o_o       (o_o),
        .o_sel_o   (o_sel_o),
        .o_valid_o (o_valid_o),
        .o_ready_i (o_ready_i)
    );

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endfunction

    function automatic bit idle();
        bit r;
        r = (exp_q.size() == 0);
        for (int k = 0; k < N; k++) begin
            if (src_q[k].size() != 0 || gen_q[k].size() != 0) r = 1'b0;
        end
        return r;
    endfunction

    // Sources present the head of their queue and hold it until accepted.
    always @(negedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (src_q[k].size() > 0) begin
                i_valid_i[k] = 1'b1;
                i_i[k]       = src_q[k][0];
            end else begin
                i_valid_i[k] = 1'b0;
                i_i[k]       = '0;
            end
        end
    end

    // Input acceptance, fairness tracking and output monitor.
    always @(posedge clk) begin
        exp_t e;
        if (arst_ni) begin
            check("rdy_onehot", 32'($onehot0(i_ready_o)), 32'd1);
            check("rdy_without_valid", 32'(i_ready_o & ~i_valid_i), 32'd0);
            for (int k = 0; k < N; k++) begin
                if (i_valid_i[k] && i_ready_o[k]) begin
                    if (rand_mode) check("starvation_wait", 32'(wait_cnt[k] < N), 32'd1);
                    wait_cnt[k] = 0;
                    void'(src_q[k].pop_front());
                end else if (i_valid_i[k] && (|(i_valid_i & i_ready_o))) begin
                    wait_cnt[k]++;
                end else if (!i_valid_i[k]) begin
                    wait_cnt[k] = 0;
                end
            end
            if (o_valid_o && o_ready_i) begin
                out_cnt++;
                if (rand_mode) begin
                    if (o_sel_o >= SW'(N) || gen_q[o_sel_o].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rand_unexpected_beat: got sel %0d data %0h, required none", o_sel_o, o_o);
                    end else begin
                        check("rand_data", 32'(o_o), 32'(gen_q[o_sel_o].pop_front()));
                    end
                end else if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got sel %0d data %0h, required none", o_sel_o, o_o);
                end else begin
                    e = exp_q.pop_front();
                    check("out_sel", 32'(o_sel_o), 32'(e.sel));
                    check("out_data", 32'(o_o), 32'(e.data));
                end
            end
        end
    end

    task automatic put_src(input int k, input logic [W-1:0] d);
        src_q[k].push_back(d);
    endtask

    task automatic put_exp(input int k, input logic [W-1:0] d);
        exp_t e;
        e.sel  = SW'(k);
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input string name);
        bit done;
        done = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge clk);
            if (idle()) done = 1'b1;
        end
        check({name, "_drain"}, 32'(done), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int base;
        int rand_out;
        bit seen;
        logic [W-1:0] seq [N];

        arst_ni   = 1'b0;
        o_ready_i = 1'b0;
        i_valid_i = '0;
        i_i       = '0;
        for (int k = 0; k < N; k++) begin
            wait_cnt[k] = 0;
            seq[k]      = '0;
        end

        // Reset state with a valid source present
        put_src(2, 8'hEE);
        o_ready_i = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_valid", 32'(o_valid_o), 32'd0);
        check("rst_ready", 32'(i_ready_o), 32'd0);
        check("rst_sel", 32'(o_sel_o), 32'd0);
        check("rst_data", 32'(o_o), 32'd0);
        src_q[2].delete();
        repeat (2) @(negedge clk);
        arst_ni = 1'b1;

        // 1: all sources valid, rotating grants on consecutive cycles
        for (int k = 0; k < N; k++) put_exp(k, 8'h10 + 8'(k));
        put_exp(0, 8'h10);
        for (int k = 0; k < N; k++) put_src(k, 8'h10 + 8'(k));
        put_src(0, 8'h10);
        base = out_cnt;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (out_cnt > base) seen = 1'b1;
        end
        repeat (6) @(negedge clk);
        check("t1_consecutive", 32'(out_cnt - base), 32'd7);
        wait_drain("t1");

        // 2: single source 3
        for (int i = 0; i < 4; i++) begin
            put_src(3, 8'hA5);
            put_exp(3, 8'hA5);
        end
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            #1;
            if (i_valid_i[3]) seen = 1'b1;
        end
        check("t2_ready_vec", 32'(i_ready_o), 32'h08);
        wait_drain("t2");
        // pointer now 4: source 4 beats source 3
        put_src(3, 8'hB3);
        put_src(4, 8'hB4);
        put_exp(4, 8'hB4);
        put_exp(3, 8'hB3);
        wait_drain("t2_ptr");
        put_src(5, 8'hC5);
        put_exp(5, 8'hC5);
        wait_drain("t2_wrap");

        // 3: stall holds the grant even when a higher-priority source appears
        @(negedge clk);
        o_ready_i = 1'b0;
        put_src(1, 8'h31);
        put_src(4, 8'h34);
        put_exp(1, 8'h31);
        put_exp(4, 8'h34);
        put_exp(0, 8'h30);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("t3_hold_sel", 32'(o_sel_o), 32'd1);
            check("t3_hold_valid", 32'(o_valid_o), 32'd1);
        end
        @(negedge clk);
        put_src(0, 8'h30);
        repeat (2) @(negedge clk);
        #1;
        check("t3_hold_sel_after_v0", 32'(o_sel_o), 32'd1);
        check("t3_hold_data", 32'(o_o), 32'h31);
        @(negedge clk);
        o_ready_i = 1'b1;
        wait_drain("t3");

        // 4: pointer at 5 wraps to 0
        put_src(4, 8'h44);
        put_exp(4, 8'h44);
        wait_drain("t4_setup");
        put_src(0, 8'h50);
        put_src(5, 8'h55);
        put_exp(5, 8'h55);
        put_exp(0, 8'h50);
        wait_drain("t4");

        // 5: reset while holding a grant
        @(negedge clk);
        o_ready_i = 1'b0;
        put_src(0, 8'h60);
        put_src(4, 8'h64);
        repeat (4) @(negedge clk);
        #1;
        check("t5_pre_sel", 32'(o_sel_o), 32'd4);
        check("t5_pre_valid", 32'(o_valid_o), 32'd1);
        @(negedge clk);
        arst_ni = 1'b0;
        #1;
        check("t5_rst_valid", 32'(o_valid_o), 32'd0);
        check("t5_rst_ready", 32'(i_ready_o), 32'd0);
        check("t5_rst_sel", 32'(o_sel_o), 32'd0);
        for (int k = 0; k < N; k++) src_q[k].delete();
        repeat (2) @(negedge clk);
        arst_ni   = 1'b1;
        o_ready_i = 1'b1;
        put_src(4, 8'h74);
        put_src(0, 8'h70);
        put_exp(0, 8'h70);
        put_exp(4, 8'h74);
        wait_drain("t5");

        // 6: random traffic, per-source ordering and fairness
        for (int k = 0; k < N; k++) wait_cnt[k] = 0;
        rand_mode = 1'b1;
        base      = out_cnt;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            o_ready_i = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < N; k++) begin
                if (src_q[k].size() < 2 && $urandom_range(0, 2) == 0) begin
                    put_src(k, seq[k]);
                    gen_q[k].push_back(seq[k]);
                    seq[k] = seq[k] + 8'd1;
                    issued++;
                end
            end
        end
        @(negedge clk);
        o_ready_i = 1'b1;
        wait_drain("t6");
        rand_out = out_cnt - base;
        check("t6_beat_count", 32'(rand_out), 32'(issued));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule
